// File: rtl/ode_pkg.sv
// Shared fixed-point helpers, FSM state encoding and default word format
// for the sequential forward-Euler ODE integrator.
package ode_pkg;

    localparam int DEF_W = 16;
    localparam int DEF_F = 7;
    localparam int WIDE  = 64;

    typedef logic signed [WIDE-1:0] wide_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_MAC,
        ST_SCALE,
        ST_UPDATE,
        ST_COMMIT,
        ST_DONE
    } state_t;

    function automatic wide_t mul_q(input wide_t x, input wide_t y);
        return x * y;
    endfunction

    // Arithmetic shift, so fractional bits are dropped toward negative infinity.
    function automatic wide_t shift_q(input wide_t x, input int f);
        return x >>> f;
    endfunction

    function automatic logic in_range_q(input wide_t x, input int w);
        wide_t lim;
        lim = wide_t'(1) <<< (w - 1);
        return (x >= -lim) && (x < lim);
    endfunction

    function automatic wide_t sat_q(input wide_t x, input int w);
        wide_t lim;
        lim = wide_t'(1) <<< (w - 1);
        if (x >= lim)
            return lim - wide_t'(1);
        else if (x < -lim)
            return -lim;
        else
            return x;
    endfunction

endpackage

// File: rtl/ode_mac.sv
// Shared W x W signed multiplier feeding a full-precision accumulator.
module ode_mac #(
    parameter int W     = 16,
    parameter int ACC_W = 35
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    enable,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic signed [ACC_W-1:0] acc
);

    localparam int PW = 2 * W;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc <= '0;
        else if (clear)
            acc <= '0;
        else if (enable)
            acc <= acc + ACC_W'(prod);
    end

endmodule

// File: rtl/ode_euler_seq.sv
// Sequential forward-Euler integrator x <- x + h*(A*x + B*u), one MAC per cycle.
// Define ODE_SATURATE_EN to clamp overflowing updates instead of wrapping them.
module ode_euler_seq
    import ode_pkg::*;
#(
    parameter int N  = 2,
    parameter int M  = 3,
    parameter int W  = DEF_W,
    parameter int F  = DEF_F,
    parameter int SW = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SW-1:0]      steps,
    input  logic [W-1:0]       h,
    input  logic [N*W-1:0]     xo,
    input  logic [N*N*W-1:0]   a,
    input  logic [M*W-1:0]     u,
    input  logic [N*M*W-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [N*W-1:0]     x_out
);

    localparam int K     = N + M;
    localparam int ACC_W = 2 * W + $clog2(K);
    localparam int IW    = $clog2(K + 1);
    localparam int RW    = $clog2(N + 1);

    state_t state_reg, state_next;

    logic signed [W-1:0] a_reg      [N][N];
    logic signed [W-1:0] b_reg      [N][M];
    logic signed [W-1:0] u_reg      [M];
    logic signed [W-1:0] xo_reg     [N];
    logic signed [W-1:0] x_cur_reg  [N];
    logic signed [W-1:0] shadow_reg [N];
    logic signed [W-1:0] h_reg;
    logic [SW-1:0]       steps_reg;
    logic [SW-1:0]       step_cnt_reg;
    logic [IW-1:0]       idx_reg;
    logic [RW-1:0]       row_reg;
    wide_t               scaled_reg;
    logic                error_reg;

    logic                    mac_clear;
    logic                    mac_en;
    logic signed [W-1:0]     op_a;
    logic signed [W-1:0]     op_b;
    logic signed [W-1:0]     x_row;
    logic signed [ACC_W-1:0] acc;
    wide_t                   upd_sum;
    wide_t                   upd_fix;
    logic                    upd_ok;

    ode_mac #(
        .W     (W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (mac_clear),
        .enable (mac_en),
        .a      (op_a),
        .b      (op_b),
        .acc    (acc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        busy       = 1'b1;
        done       = 1'b0;
        mac_clear  = 1'b0;
        mac_en     = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = ST_LOAD;
            end
            ST_LOAD: begin
                mac_clear  = 1'b1;
                state_next = (steps_reg == '0) ? ST_DONE : ST_MAC;
            end
            ST_MAC: begin
                mac_en = 1'b1;
                if (idx_reg == IW'(K - 1))
                    state_next = ST_SCALE;
            end
            ST_SCALE: begin
                // Row sum is captured into scaled_reg on this edge, so the
                // accumulator can be cleared for the next row at the same time.
                mac_clear  = 1'b1;
                state_next = ST_UPDATE;
            end
            ST_UPDATE: state_next = (row_reg == RW'(N - 1)) ? ST_COMMIT : ST_MAC;
            ST_COMMIT: state_next = (step_cnt_reg == SW'(1)) ? ST_DONE : ST_MAC;
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Operands: columns 0..N-1 walk A*x, columns N..N+M-1 walk B*u.
    always_comb begin
        op_a  = '0;
        op_b  = '0;
        x_row = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(row_reg) == i) begin
                x_row = x_cur_reg[i];
                for (int j = 0; j < N; j++) begin
                    if (int'(idx_reg) == j) begin
                        op_a = a_reg[i][j];
                        op_b = x_cur_reg[j];
                    end
                end
                for (int k = 0; k < M; k++) begin
                    if (int'(idx_reg) == N + k) begin
                        op_a = b_reg[i][k];
                        op_b = u_reg[k];
                    end
                end
            end
        end
        upd_sum = wide_t'(x_row) + scaled_reg;
        upd_ok  = in_range_q(upd_sum, W);
`ifdef ODE_SATURATE_EN
        upd_fix = sat_q(upd_sum, W);
`else
        upd_fix = upd_sum;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                for (int j = 0; j < N; j++)
                    a_reg[i][j] <= '0;
                for (int k = 0; k < M; k++)
                    b_reg[i][k] <= '0;
                xo_reg[i]     <= '0;
                x_cur_reg[i]  <= '0;
                shadow_reg[i] <= '0;
            end
            for (int k = 0; k < M; k++)
                u_reg[k] <= '0;
            h_reg        <= '0;
            steps_reg    <= '0;
            step_cnt_reg <= '0;
            idx_reg      <= '0;
            row_reg      <= '0;
            scaled_reg   <= '0;
            error_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < N; i++) begin
                            for (int j = 0; j < N; j++)
                                a_reg[i][j] <= a[(N*N-1-(i*N+j))*W +: W];
                            for (int k = 0; k < M; k++)
                                b_reg[i][k] <= b[(N*M-1-(i*M+k))*W +: W];
                            xo_reg[i] <= xo[(N-1-i)*W +: W];
                        end
                        for (int k = 0; k < M; k++)
                            u_reg[k] <= u[(M-1-k)*W +: W];
                        h_reg        <= h;
                        steps_reg    <= steps;
                        step_cnt_reg <= steps;
                        error_reg    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    for (int i = 0; i < N; i++)
                        x_cur_reg[i] <= xo_reg[i];
                    idx_reg <= '0;
                    row_reg <= '0;
                end
                ST_MAC: idx_reg <= (idx_reg == IW'(K - 1)) ? '0 : idx_reg + IW'(1);
                ST_SCALE: scaled_reg <= shift_q(mul_q(shift_q(wide_t'(acc), F), wide_t'(h_reg)), F);
                ST_UPDATE: begin
                    for (int i = 0; i < N; i++) begin
                        if (int'(row_reg) == i)
                            shadow_reg[i] <= W'(upd_fix);
                    end
                    if (!upd_ok)
                        error_reg <= 1'b1;
                    row_reg <= (row_reg == RW'(N - 1)) ? '0 : row_reg + RW'(1);
                end
                ST_COMMIT: begin
                    for (int i = 0; i < N; i++)
                        x_cur_reg[i] <= shadow_reg[i];
                    step_cnt_reg <= step_cnt_reg - SW'(1);
                end
                default: ;
            endcase
        end
    end

    assign error = error_reg;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_xout
            assign x_out[(N-1-gi)*W +: W] = x_cur_reg[gi];
        end
    endgenerate

endmodule

// File: tb/tb_ode_euler_seq.sv
// Directed self-checking bench for ode_euler_seq with hand-computed Q9.7 results.
module tb_ode_euler_seq;

    localparam int N  = 2;
    localparam int M  = 3;
    localparam int W  = 16;
    localparam int F  = 7;
    localparam int SW = 8;

`ifdef ODE_SATURATE_EN
    localparam logic [W-1:0] OVF_X0 = 16'h7FFF;
`else
    localparam logic [W-1:0] OVF_X0 = 16'hC900;
`endif

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic [SW-1:0]      steps;
    logic [W-1:0]       h;
    logic [N*W-1:0]     xo;
    logic [N*N*W-1:0]   a;
    logic [M*W-1:0]     u;
    logic [N*M*W-1:0]   b;
    logic               busy;
    logic               done;
    logic               error;
    logic [N*W-1:0]     x_out;

    int checks   = 0;
    int failures = 0;
    int lat;
    bit seen_done;

    always #5 clk = ~clk;

    ode_euler_seq #(
        .N (N), .M (M), .W (W), .F (F), .SW (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .steps (steps),
        .h     (h),
        .xo    (xo),
        .a     (a),
        .u     (u),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .error (error),
        .x_out (x_out)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    // Start one run and wait (bounded) for done; optionally disturb it while busy
    // and raise start during the DONE cycle, which must both be ignored.
    task automatic run_op(input string tag, input logic [SW-1:0] st, input logic [W-1:0] hv,
                          input logic [N*W-1:0] xv, input logic [N*N*W-1:0] av,
                          input logic [M*W-1:0] uv, input logic [N*M*W-1:0] bv,
                          input bit disturb, output int lat_o);
        @(negedge clk);
        steps = st; h = hv; xo = xv; a = av; u = uv; b = bv;
        start = 1'b1;
        @(posedge clk);
        lat_o = 1;
        @(negedge clk);
        start = 1'b0;
        check({tag, "_busy"}, 32'(busy), 32'd1);
        while (!done && lat_o < 200) begin
            @(posedge clk);
            #1;
            lat_o++;
            if (disturb && lat_o == 5) begin
                start = 1'b1;
                h     = 16'h7000;
                xo    = {16'h1000, 16'h2000};
                a     = '1;
                u     = '1;
            end
            if (disturb && lat_o == 6)
                start = 1'b0;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        $display("run %s: steps=%0d latency=%0d x_out=%h error=%b", tag, st, lat_o, x_out, error);
        if (disturb) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            check({tag, "_done_cycle_start"}, 32'(busy), 32'd0);
        end else begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        steps = '0; h = '0; xo = '0; a = '0; u = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy",  32'(busy),  32'd0);
        check("rst_done",  32'(done),  32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_x_out", 32'(x_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // h=2, x=[1,2], A=[[1,1],[0,1]], B*u = 14 on row 0
        run_op("basic", 8'd1, 16'h0100, {16'h0080, 16'h0100},
               {16'h0080, 16'h0080, 16'h0000, 16'h0080}, {16'h0080, 16'h0100, 16'h0180},
               {16'h0080, 16'h0100, 16'h0180, 16'h0000, 16'h0000, 16'h0000}, 1'b0, lat);
        check("basic_lat", 32'(lat), 32'd17);
        check("basic_x0", 32'(x_out[31:16]), 32'h1180);
        check("basic_x1", 32'(x_out[15:0]),  32'h0300);
        check("basic_err", 32'(error), 32'd0);

        run_op("neg", 8'd1, 16'h0080, {16'hFE00, 16'h0000},
               {16'hFEC0, 16'h0000, 16'h0000, 16'h0000}, '0, '0, 1'b0, lat);
        check("neg_x0", 32'(x_out[31:16]), 32'h0300);
        check("neg_x1", 32'(x_out[15:0]),  32'h0000);
        check("neg_err", 32'(error), 32'd0);

        run_op("multi", 8'd3, 16'h0080, {16'h0080, 16'h0000},
               {16'h0040, 16'h0000, 16'h0000, 16'h0000}, '0, '0, 1'b0, lat);
        check("multi_lat", 32'(lat), 32'd47);
        check("multi_x0", 32'(x_out[31:16]), 32'h01B0);
        check("multi_x1", 32'(x_out[15:0]),  32'h0000);

        run_op("ovf", 8'd1, 16'h0080, {16'h0100, 16'h0100},
               {16'h3200, 16'h3200, 16'h0000, 16'h0000}, '0, '0, 1'b0, lat);
        check("ovf_err", 32'(error), 32'd1);
        check("ovf_x0", 32'(x_out[31:16]), 32'(OVF_X0));
        check("ovf_x1", 32'(x_out[15:0]),  32'h0100);

        // Also shows the sticky error is cleared by the next accepted start.
        run_op("zero", 8'd0, 16'h0080, {16'h0180, 16'hFF80},
               {16'h0080, 16'h0080, 16'h0080, 16'h0080}, '0, '0, 1'b0, lat);
        check("zero_lat", 32'(lat), 32'd2);
        check("zero_x0", 32'(x_out[31:16]), 32'h0180);
        check("zero_x1", 32'(x_out[15:0]),  32'hFF80);
        check("zero_err", 32'(error), 32'd0);

        run_op("disturb", 8'd1, 16'h0100, {16'h0080, 16'h0100},
               {16'h0080, 16'h0080, 16'h0000, 16'h0080}, {16'h0080, 16'h0100, 16'h0180},
               {16'h0080, 16'h0100, 16'h0180, 16'h0000, 16'h0000, 16'h0000}, 1'b1, lat);
        check("disturb_lat", 32'(lat), 32'd17);
        check("disturb_x0", 32'(x_out[31:16]), 32'h1180);
        check("disturb_x1", 32'(x_out[15:0]),  32'h0300);

        // Abort a run in MAC with reset.
        @(negedge clk);
        steps = 8'd1; h = 16'h0100; xo = {16'h0080, 16'h0100};
        a = {16'h0080, 16'h0080, 16'h0000, 16'h0080};
        u = {16'h0080, 16'h0100, 16'h0180};
        b = {16'h0080, 16'h0100, 16'h0180, 16'h0000, 16'h0000, 16'h0000};
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_x_out", 32'(x_out), 32'd0);
        check("abort_busy",  32'(busy),  32'd0);
        check("abort_done",  32'(done),  32'd0);
        seen_done = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done) seen_done = 1'b1;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        check("abort_idle", 32'(busy), 32'd0);

        run_op("after_rst", 8'd1, 16'h0100, {16'h0080, 16'h0100},
               {16'h0080, 16'h0080, 16'h0000, 16'h0080}, {16'h0080, 16'h0100, 16'h0180},
               {16'h0080, 16'h0100, 16'h0180, 16'h0000, 16'h0000, 16'h0000}, 1'b0, lat);
        check("after_rst_lat", 32'(lat), 32'd17);
        check("after_rst_x0", 32'(x_out[31:16]), 32'h1180);
        check("after_rst_x1", 32'(x_out[15:0]),  32'h0300);
        check("after_rst_err", 32'(error), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ode_euler_seq.md
ODE_EULER_SEQ -- requirements
Module: ode_euler_seq

Interface
REQ-001 SHALL have parameter N, default 2, meaning number of state variables.
REQ-002 SHALL have parameter M, default 3, meaning number of input variables.
REQ-003 SHALL have parameter W, default 16, meaning signed fixed-point word width.
REQ-004 SHALL have parameter F, default 7, meaning fractional bits, giving Q(W-F).F format.
REQ-005 SHALL have parameter SW, default 8, meaning step-count width.
REQ-006 SHALL use one clock and an asynchronous active-low reset.
REQ-007 SHALL have ports as follows; clk and rst_n come first:
- clk  in  1  rising-edge clock
- rst_n  in  1  async active-low reset
- start  in  1  one-cycle request; sampled only in IDLE
- steps  in  SW  Euler iterations to run
- h  in  W  step size
- xo  in  N*W  initial state; element 0 in the MSBs
- a  in  N*N*W  A matrix, row-major; a[0][0] in the MSBs
- u  in  M*W  input vector
- b  in  N*M*W  B matrix, row-major
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  overflow flag, sticky for the run
- x_out  out  N*W  current state vector

Function
REQ-008 SHALL compute x[i] <- x[i] + h*(sum_j a[i][j]*x[j] + sum_k b[i][k]*u[k]) each step, using the pre-step x for every row.
REQ-009 SHALL register all inputs on an accepted start; input changes during busy SHALL have no effect.
REQ-010 SHALL use one shared W x W signed multiplier; row products accumulate at full precision (2W+clog2(N+M) bits).
REQ-011 SHALL arithmetic-shift the row sum right by F, multiply by h, shift right by F again, then add x[i]; all shifts round toward negative infinity.
REQ-012 SHALL FSM through IDLE -> LOAD -> MAC -> SCALE -> UPDATE -> (MAC for the next row | COMMIT) -> (MAC for the next step | DONE) -> IDLE.
REQ-013 SHALL spend N+M cycles in MAC per row, and 1 cycle each in SCALE, UPDATE and COMMIT.
REQ-014 SHALL produce total latency from the start edge to the done pulse of 2 + steps*(N*(N+M+2)+1) cycles.
REQ-015 SHALL write row results into a shadow buffer and copy them to x_out only in COMMIT.
REQ-016 SHALL, when steps==0, set x_out=xo with no arithmetic, and pulse done 2 cycles after start.
REQ-017 SHALL ignore start while busy=1; a start in the DONE cycle SHALL also be ignored.
REQ-018 SHALL set error when any UPDATE result lies outside the W-bit signed range; error SHALL remain set until the next accepted start clears it.
REQ-019 SHALL hold busy=1 from the cycle after start through the DONE cycle; done=1 only in DONE.

Reset
REQ-020 SHALL, while rst_n=0, immediately force state=IDLE, busy=0, done=0, error=0, x_out=0, and clear the accumulator and shadow buffer.
REQ-021 SHALL abort a mid-run operation on reset with no done pulse; the first start after reset release SHALL be accepted normally.

Configuration
REQ-022 SHALL, when macro ODE_SATURATE_EN is defined, clamp overflowing UPDATE results to 0x7FFF or 0x8000 (scaled to W).
REQ-023 SHALL, without ODE_SATURATE_EN, wrap overflowing results to the low W bits; error behaviour SHALL be identical in both builds.

Structure
REQ-024 SHALL place the fixed-point helpers (mul_q, shift_q, range-check and saturate functions), the state enum and the default W/F constants in shared package ode_pkg.
REQ-025 SHALL implement the multiplier and accumulator as sub-module ode_mac (clear, enable, a, b, acc out); the FSM and buffers SHALL stay in ode_euler_seq.

Verification (N=2, M=3, W=16, F=7)
REQ-026 SHALL test: h=2, steps=1, A=[[1,1],[0,1]], xo=[1,2], B=[[1,2,3],[0,0,0]], u=[1,2,3] -> x_out=[0x1180,0x0300], error=0, done exactly 2+(2*7+1)=17 cycles after start.
REQ-027 SHALL test negatives: h=1, A=[[-2.5,0],[0,0]], xo=[-4,0], B=0 -> x_out[0]=0x0300, x_out[1]=0x0000, error=0.
REQ-028 SHALL test multi-step: h=1, steps=3, A=[[0.5,0],[0,0]], xo=[1,0], B=0 -> x_out[0]=0x01B0 (3.375), done at cycle 47.
REQ-029 SHALL test overflow: h=1, A=[[100,100],[0,0]], xo=[2,2], B=0 -> error=1; x_out[0]=0x7FFF with ODE_SATURATE_EN, 0xC900 without it.
REQ-030 SHALL test control robustness: a second start and changed inputs during busy are ignored (result unchanged); rst_n low in MAC gives outputs 0 and no done, then a fresh start completes correctly.
REQ-031 SHALL test steps=0 with xo=[3,-1] -> x_out=[0x0180,0xFF80], done 2 cycles after start, error=0.
